result_serializer: RTL and testbench

RESULT_SERIALIZER -- requirements
Module: result_serializer

---
 rtl/hpu_pkg.sv | 14 +
 rtl/result_serializer.sv | 101 ++++++++++
 tb/tb_result_serializer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/hpu_pkg.sv
// hpu_pkg: shared hypervector dimensions and serializer FSM state type.
// Consumed by result_serializer (optional HPU_VEC_COUNT_EN lives there).
`default_nettype none
package hpu_pkg;
  localparam int DIM       = 1023;
  localparam int BEAT_W    = 256;
  localparam int NUM_BEATS = (DIM + 1) / BEAT_W;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;
endpackage
`default_nettype wire

// File: rtl/result_serializer.sv
// result_serializer: captures a DIM+1 sign vector and streams it as BEAT_W beats, LSB beat first.
// Optional macro HPU_VEC_COUNT_EN adds a 32-bit count of fully delivered vectors.
`default_nettype none
module result_serializer #(
  parameter int DIM    = hpu_pkg::DIM,
  parameter int BEAT_W = hpu_pkg::BEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM:0]      sign_bit,
  input  logic              dst_ready,
  output logic              dst_valid,
  output logic [BEAT_W-1:0] dst_data,
  output logic              dst_last,
  output logic              busy,
  output logic              start_drop
`ifdef HPU_VEC_COUNT_EN
  ,
  output logic [31:0]       vec_count
`endif
);
  import hpu_pkg::*;

  localparam int NBEATS = (DIM + 1) / BEAT_W;
  localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

  state_t            state, state_nxt;
  logic [DIM:0]      hold, hold_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic              drop_nxt;
  logic              hs;
  logic              hs_last;
  logic [BEAT_W-1:0] beat [NBEATS];

  for (genvar g = 0; g < NBEATS; g++) begin : g_beat
    assign beat[g] = hold[g*BEAT_W +: BEAT_W];
  end

  assign hs         = (state == SEND) && dst_ready;
  assign hs_last    = hs && (idx == LAST_IDX);
  assign dst_valid  = (state == SEND);
  assign busy       = (state == SEND);
  assign dst_last   = dst_valid && (idx == LAST_IDX);
  assign dst_data   = dst_valid ? beat[idx] : '0;

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    idx_nxt   = idx;
    drop_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          hold_nxt  = sign_bit;
          idx_nxt   = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (hs_last) begin
          // A start on the final handshake chains the next vector without a bubble.
          if (start) begin
            hold_nxt = sign_bit;
            idx_nxt  = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          if (hs) idx_nxt = idx + 1'b1;
          drop_nxt = start;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hold       <= '0;
      idx        <= '0;
      start_drop <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold       <= hold_nxt;
      idx        <= idx_nxt;
      start_drop <= drop_nxt;
    end
  end

`ifdef HPU_VEC_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)          vec_count <= '0;
    else if (hs_last) vec_count <= vec_count + 32'd1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_result_serializer.sv
// tb_result_serializer: directed scenarios plus random traffic checked against a beat-queue model.
`default_nettype none
module tb_result_serializer;
  import hpu_pkg::*;

  localparam int BW = BEAT_W;
  localparam int NB = NUM_BEATS;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DIM:0]  sign_bit;
  logic          dst_ready;
  logic          dst_valid;
  logic [BW-1:0] dst_data;
  logic          dst_last;
  logic          busy;
  logic          start_drop;
`ifdef HPU_VEC_COUNT_EN
  logic [31:0]   vec_count;
`endif

  result_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sign_bit   (sign_bit),
    .dst_ready  (dst_ready),
    .dst_valid  (dst_valid),
    .dst_data   (dst_data),
    .dst_last   (dst_last),
    .busy       (busy),
    .start_drop (start_drop)
`ifdef HPU_VEC_COUNT_EN
    ,
    .vec_count  (vec_count)
`endif
  );

  always #5 clk = ~clk;

  int            checks   = 0;
  int            failures = 0;
  logic [BW-1:0] exp_q [$];
  logic          exp_drop = 1'b0;
  logic [31:0]   exp_cnt  = '0;

  logic [DIM:0] v1;
  logic [DIM:0] v5;

  function automatic logic [DIM:0] rand_vec();
    logic [DIM:0] rv;
    rv = '0;
    for (int i = 0; i < (DIM + 1) / 32; i++) rv[i*32 +: 32] = $urandom;
    return rv;
  endfunction

  // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model.
  task automatic step(input logic s, input logic [DIM:0] v, input logic r, input logic rs);
    int            n;
    logic          hs;
    logic          hs_last;
    logic          take;
    logic [BW-1:0] exp_data;
    rst = rs; start = s; sign_bit = v; dst_ready = r;
    @(negedge clk);
    n = exp_q.size();
    exp_data = (n > 0) ? exp_q[0] : '0;
    checks++;
    if (dst_valid !== (n > 0)) begin
      failures++; $display("FAIL dst_valid got=%b exp=%b t=%0t", dst_valid, (n > 0), $time);
    end
    checks++;
    if (busy !== (n > 0)) begin
      failures++; $display("FAIL busy got=%b exp=%b t=%0t", busy, (n > 0), $time);
    end
    checks++;
    if (dst_last !== (n == 1)) begin
      failures++; $display("FAIL dst_last got=%b exp=%b t=%0t", dst_last, (n == 1), $time);
    end
    checks++;
    if (dst_data !== exp_data) begin
      failures++; $display("FAIL dst_data got=%h exp=%h t=%0t", dst_data, exp_data, $time);
    end
    checks++;
    if (start_drop !== exp_drop) begin
      failures++; $display("FAIL start_drop got=%b exp=%b t=%0t", start_drop, exp_drop, $time);
    end
`ifdef HPU_VEC_COUNT_EN
    checks++;
    if (vec_count !== exp_cnt) begin
      failures++; $display("FAIL vec_count got=%0d exp=%0d t=%0t", vec_count, exp_cnt, $time);
    end
`endif
    @(posedge clk);
    if (rs) begin
      exp_q.delete();
      exp_drop = 1'b0;
      exp_cnt  = '0;
    end else begin
      hs      = (n > 0) && r;
      hs_last = hs && (n == 1);
      take    = s && ((n == 0) || hs_last);
      if (hs) void'(exp_q.pop_front());
      if (hs_last) exp_cnt = exp_cnt + 32'd1;
      exp_drop = s && !take;
      if (take) for (int i = 0; i < NB; i++) exp_q.push_back(v[i*BW +: BW]);
    end
    #1;
  endtask

  task automatic idle(input int cycles, input logic r);
    for (int i = 0; i < cycles; i++) step(1'b0, '0, r, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, rand_vec(), 1'b1, 1'b1);
    idle(2, 1'b1);
  endtask

  task automatic test_stream();
    step(1'b1, v1, 1'b1, 1'b0);
    idle(6, 1'b1);
  endtask

  task automatic test_backpressure();
    step(1'b1, v1, 1'b1, 1'b0);
    idle(1, 1'b1);
    idle(3, 1'b0);
    idle(5, 1'b1);
  endtask

  task automatic test_back_to_back();
    step(1'b1, v1, 1'b1, 1'b0);
    idle(3, 1'b1);
    step(1'b1, v5, 1'b1, 1'b0);
    idle(6, 1'b1);
  endtask

  task automatic test_start_drop();
    step(1'b1, v1, 1'b1, 1'b0);
    idle(1, 1'b1);
    step(1'b1, rand_vec(), 1'b0, 1'b0);
    step(1'b1, rand_vec(), 1'b1, 1'b0);
    idle(6, 1'b1);
  endtask

  task automatic test_reset_midstream();
    step(1'b1, v1, 1'b1, 1'b0);
    idle(2, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    idle(1, 1'b1);
    step(1'b1, v5, 1'b1, 1'b0);
    idle(6, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) == 0, rand_vec(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 80) == 0);
    idle(8, 1'b1);
  endtask

`ifdef HPU_VEC_COUNT_EN
  task automatic test_vec_count();
    step(1'b0, '0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, rand_vec(), 1'b1, 1'b0);
      idle(5, 1'b1);
    end
    force dut.vec_count = 32'hFFFF_FFFF;
    #1;
    release dut.vec_count;
    exp_cnt = 32'hFFFF_FFFF;
    step(1'b1, rand_vec(), 1'b1, 1'b0);
    idle(5, 1'b1);
  endtask
`endif

  initial begin
    v1 = {256'hD, 256'hC, 256'hB, 256'hA};
    v5 = {4{256'h5}};
    rst = 1'b1; start = 1'b0; dst_ready = 1'b0; sign_bit = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_start_drop();
    test_reset_midstream();
    test_random();
`ifdef HPU_VEC_COUNT_EN
    test_vec_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
